// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage feeding the IF/ID register; owns the PC and
//   fetches over a req/ack memory handshake, emitting bubbles (inst_o=0) while a
//   fetch is outstanding. Handles redirects, including one that races a live fetch.
// Latency: 1 inst per 2 cycles minimum from memory; with ICACHE_EN defined, hits
//   deliver 1 inst/cycle.
// Backpressure: stall_signal[0] freezes the stage in IDLE (outputs hold). An
//   issued request is never withdrawn; the stage always accepts its ack.
// Optional feature macro: ICACHE_EN (direct-mapped I-cache, 2^ICACHE_IDX_W lines).

`ifndef StallSignalLen
`define StallSignalLen 6
`endif

module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_IDX_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`StallSignalLen-1:0] stall_signal,
  input  logic                       jump_flag,
  input  logic [31:0]                jump_target_i,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [31:0]                mem_inst_i,
  output logic [31:0]                pc_o,
  output logic [31:0]                inst_o
);

  // IDLE: may issue/hit; WAIT: fetch live and wanted; DROP: fetch live but stale.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] jump_pc;
  logic        fetch_accept;
  logic        cache_hit;
  logic [31:0] cache_line;

  // Instructions are word aligned, so the low two target bits are dropped.
  assign jump_pc = {jump_target_i[31:2], 2'b00};
  // Plain 32-bit add: the PC wraps from 0xFFFFFFFC to 0.
  assign pc_next = pc + 32'd4;

  // An ack is only consumed as an instruction when the fetch was not redirected.
  assign fetch_accept = (state == S_WAIT) && mem_ack_i && !jump_flag;

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  logic [LINES-1:0]        c_valid;
  logic [TAG_W-1:0]        c_tag  [LINES];
  logic [31:0]             c_data [LINES];
  logic [ICACHE_IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0]        rd_tag;
  logic [ICACHE_IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0]        wr_tag;

  assign rd_idx     = pc[ICACHE_IDX_W+1:2];
  assign rd_tag     = pc[31:ICACHE_IDX_W+2];
  // mem_addr_o is the address of the live fetch, so it indexes the fill.
  assign wr_idx     = mem_addr_o[ICACHE_IDX_W+1:2];
  assign wr_tag     = mem_addr_o[31:ICACHE_IDX_W+2];
  assign cache_hit  = c_valid[rd_idx] && (c_tag[rd_idx] == rd_tag);
  assign cache_line = c_data[rd_idx];

  // Valid bits are the only cache state that must be cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid <= '0;
    end else if (fetch_accept) begin
      c_valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: written by accepted fills only, no reset so they map to RAM.
  always_ff @(posedge clk) begin
    if (fetch_accept) begin
      c_tag[wr_idx]  <= wr_tag;
      c_data[wr_idx] <= mem_inst_i;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_line = 32'h0;
`endif

  // Only stall bit 0 matters here; the stall controller guarantees bit1 implies bit0.
  logic unused_inputs;
  assign unused_inputs = ^{stall_signal[`StallSignalLen-1:1], jump_target_i[1:0],
                           ICACHE_IDX_W, fetch_accept};

  // Fetch FSM with all outputs registered. Priority: reset > jump > stall > fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= {RESET_PC[31:2], 2'b00};
      pc_o       <= 32'h0;
      inst_o     <= 32'h0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (jump_flag) begin
            // Redirect with a bubble; fetch starts from the target next edge.
            pc     <= jump_pc;
            pc_o   <= 32'h0;
            inst_o <= 32'h0;
          end else if (stall_signal[0]) begin
            // Frozen: the delivered instruction and the PC hold.
            state <= S_IDLE;
          end else if (cache_hit) begin
            pc_o   <= pc;
            inst_o <= cache_line;
            pc     <= pc_next;
          end else begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= pc;
            pc_o       <= 32'h0;
            inst_o     <= 32'h0;
            state      <= S_WAIT;
          end
        end

        S_WAIT: begin
          // stall is ignored here: the memory ack must be taken when it comes.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= S_IDLE;
            if (jump_flag) begin
              // Redirect wins over the returning word; it is thrown away.
              pc <= jump_pc;
            end else begin
              pc_o   <= pc;
              inst_o <= mem_inst_i;
              pc     <= pc_next;
            end
          end else if (jump_flag) begin
            // Request cannot be withdrawn; wait for its ack and drop it.
            pc    <= jump_pc;
            state <= S_DROP;
          end
        end

        S_DROP: begin
          // Latest redirect wins while the stale fetch drains.
          if (jump_flag) begin
            pc <= jump_pc;
          end
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
